elevator_request_queue: RTL and testbench
=========================================

# elevator_request_queue

Parametrised front end for the elevator controller. It synchronises and debounces the three button banks: hall-up, hall-down and in-car. It turns each debounced press into a sticky pending request and holds that request until the controller reports the floor served in the matching direction. It also provides above/below/here summaries relative to the current car floor.

## Interface
Parameters:
- FLOORS, 4, number of floors (≥2); bit i = floor i, floor 0 lowest
- DEB_CYCLES, 200, consecutive stable clk cycles needed to accept a level change (≥2)
- FW, $clog2(FLOORS), width of floor index (derived, not overridden)

Ports:
- clk  in  1  design clock, 200 MHz
- rst  in  1  asynchronous reset, active-high; one clock, no other clock domains
- outside_up  in  FLOORS  raw hall-up buttons, high = pressed, asynchronous
- outside_down  in  FLOORS  raw hall-down buttons, high = pressed, asynchronous
- inside_floor  in  FLOORS  raw car buttons, high = pressed, asynchronous
- cur_floor  in  FW  current car floor index
- serve_valid  in  1  one-cycle pulse: car is serving cur_floor
- serve_dir  in  1  direction served: 1 = up, 0 = down
- queue_up  out  FLOORS  pending hall-up requests (registered)
- queue_down  out  FLOORS  pending hall-down requests (registered)
- queue_inside  out  FLOORS  pending car requests (registered)
- req_above  out  1  any pending request at a floor > cur_floor (combinational)
- req_below  out  1  any pending request at a floor < cur_floor (combinational)
- req_here  out  1  any pending request at cur_floor (combinational)

## Operation
- There are 3×FLOORS identical button channels. Each channel contains:
  - a 2-flop synchroniser, sync1 then sync2
  - a debounced level db
  - a counter cnt of width $clog2(DEB_CYCLES)
- Debounce rules, evaluated each clk edge:
  - sync2 == db: cnt ← 0.
  - sync2 != db and cnt < DEB_CYCLES-1: cnt ← cnt+1.
  - sync2 != db and cnt == DEB_CYCLES-1: db ← sync2, cnt ← 0.
- Press event: an internal pulse on the edge after db goes 0→1. A db 1→0 transition (release) produces no event.
- Holding a button never re-triggers. A glitch shorter than DEB_CYCLES sync2 cycles is ignored entirely.
- Request latch per channel bit:
  - Set on a press event.
  - Clear when serve_valid=1 and cur_floor=i:
    - queue_inside[i] always clears;
    - queue_up[i] clears when serve_dir=1;
    - queue_down[i] clears when serve_dir=0.
  - Set and clear in the same cycle: clear wins. The request counts as served.
- Tie-offs:
  - queue_up[FLOORS-1] and queue_down[0] are constant 0; presses on those buttons are discarded.
  - Their debounce logic may be optimised away.
- Summaries: let P[i] = queue_up[i] | queue_down[i] | queue_inside[i].
  - req_above = OR of P[j] for j > cur_floor.
  - req_below = OR of P[j] for j < cur_floor.
  - req_here = P[cur_floor].
- cur_floor ≥ FLOORS is illegal:
  - serve_valid is ignored;
  - req_above, req_below and req_here are all 0;
  - the queues hold.
- Multiple presses in different channels in the same cycle are all latched independently.

## Timing
- Reset, asynchronous, effective immediately: sync1, sync2, db, cnt and all queue_* are 0. The summaries follow as 0.
- Latency: raw input first sampled high at edge E0:
  - sync2 is high at E0+1;
  - db rises at E0+1+DEB_CYCLES;
  - queue bit rises at E0+2+DEB_CYCLES, provided raw stays high from E0 onward.
- Clear latency: queue bit falls at the edge where serve_valid is sampled high. Summaries update the same cycle.
- Summaries are purely combinational from the registered queues and cur_floor. They add no register delay.
- Reset asserted mid-debounce or mid-request:
  - all state is lost;
  - a button still held when reset releases is treated as a new press.
  - It latches DEB_CYCLES+2 edges after the first post-reset sampling edge.
- Bounce: any cycle with sync2 == db restarts the count. Acceptance therefore needs an uninterrupted run of DEB_CYCLES mismatching cycles.

## Test plan
Tests 1–4 and 6 use FLOORS=4, DEB_CYCLES=4.
- **Clean press:** reset, then inside_floor=4'b0100 held from E0.
  - queue_inside=4'b0100 first at E0+6, not at E0+5.
  - With cur_floor=0: req_above=1, req_below=0, req_here=0.
- **Glitch and bounce rejection:**
  - outside_up[1] high for 3 cycles, then low: queue_up stays 0.
  - Pattern 1,1,0,1,1,1,1 held: latched 6 edges after the last 0→1 sample.
- **Directional clear:** queue_up[2] and queue_down[2] pending, cur_floor=2.
  - serve_valid pulse with serve_dir=1: queue_up[2]→0 at that edge, queue_down[2] stays 1, req_here stays 1.
  - Second pulse with serve_dir=0: req_here→0.
- **Simultaneous set/clear and hold:**
  - A press event on inside_floor[1] in the same cycle as serve_valid at floor 1: queue_inside[1]=0.
  - Button kept held afterwards: no re-latch.
- **Tie-offs and illegal floor:**
  - Pressing outside_up[3] and outside_down[0]: both queues stay 0.
  - FLOORS=5, cur_floor=7 with requests pending: all summaries 0, serve ignored, queues unchanged.
- **Reset mid-operation:**
  - Assert rst while outside_down[3] is mid-debounce and queue_inside=4'b1001: all outputs 0 immediately.
  - Button still held after release: queue_down[3] set 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/elevator_request_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// elevator_request_queue
//
// Front end for the elevator controller. It synchronises and debounces the
// hall-up, hall-down and in-car button banks. Each accepted press becomes a
// sticky pending request, held until the controller serves that floor in the
// matching direction. It also reports whether any request is pending above,
// below or at the current car floor.
//
// Parameters
//   FLOORS      number of floors (>= 2); bit i = floor i, floor 0 lowest
//   DEB_CYCLES  consecutive stable cycles needed to accept a level change
//   FW          width of a floor index (derived from FLOORS)
//
// Ports
//   clk           design clock
//   rst           asynchronous reset, active-high
//   outside_up    raw hall-up buttons (asynchronous, high = pressed)
//   outside_down  raw hall-down buttons (asynchronous, high = pressed)
//   inside_floor  raw in-car buttons (asynchronous, high = pressed)
//   cur_floor     current car floor index
//   serve_valid   one-cycle pulse: car is serving cur_floor
//   serve_dir     direction served: 1 = up, 0 = down
//   queue_up      pending hall-up requests (registered)
//   queue_down    pending hall-down requests (registered)
//   queue_inside  pending in-car requests (registered)
//   req_above     any pending request above cur_floor (combinational)
//   req_below     any pending request below cur_floor (combinational)
//   req_here      any pending request at cur_floor (combinational)
// -----------------------------------------------------------------------------
module elevator_request_queue #(
    parameter int FLOORS     = 4,
    parameter int DEB_CYCLES = 200,
    parameter int FW         = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] outside_up,
    input  logic [FLOORS-1:0] outside_down,
    input  logic [FLOORS-1:0] inside_floor,
    input  logic [FW-1:0]     cur_floor,
    input  logic              serve_valid,
    input  logic              serve_dir,
    output logic [FLOORS-1:0] queue_up,
    output logic [FLOORS-1:0] queue_down,
    output logic [FLOORS-1:0] queue_inside,
    output logic              req_above,
    output logic              req_below,
    output logic              req_here
);

    // Channel layout: bank 0 = hall-up, bank 1 = hall-down, bank 2 = in-car.
    // Channel index = bank * FLOORS + floor.
    localparam int NCH = 3 * FLOORS;
    localparam int CW  = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    // Top floor has no hall-up button and floor 0 has no hall-down button.
    localparam logic [FLOORS-1:0] UP_MASK = ~(FLOORS'(1) << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_MASK = ~FLOORS'(1);

    logic [NCH-1:0] raw_all;
    logic [NCH-1:0] press;

    assign raw_all = {inside_floor, outside_down, outside_up};

    // -------------------------------------------------------------------------
    // Per-channel synchroniser + debouncer + press-edge detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            localparam int  BANK = gi / FLOORS;
            localparam int  FLR  = gi % FLOORS;
            localparam bit  TIED = ((BANK == 0) && (FLR == FLOORS - 1)) ||
                                   ((BANK == 1) && (FLR == 0));

            if (TIED) begin : g_tied
                // Button that cannot exist on this floor: presses are dropped.
                logic tie_unused;
                assign tie_unused = raw_all[gi];
                assign press[gi]  = 1'b0;
            end else begin : g_live
                logic          sync1_q;
                logic          sync2_q;
                logic          db_q;
                logic          db_d;
                logic          db_prev_q;
                logic [CW-1:0] cnt_q;
                logic [CW-1:0] cnt_d;

                // Any cycle where the synchronised level agrees with the
                // debounced level restarts the count, so acceptance needs an
                // uninterrupted run of DEB_CYCLES mismatching cycles.
                always_comb begin
                    db_d  = db_q;
                    cnt_d = '0;
                    if (sync2_q != db_q) begin
                        if (cnt_q == CNT_LAST) begin
                            db_d = sync2_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sync1_q   <= 1'b0;
                        sync2_q   <= 1'b0;
                        db_q      <= 1'b0;
                        db_prev_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        sync1_q   <= raw_all[gi];
                        sync2_q   <= sync1_q;
                        db_q      <= db_d;
                        db_prev_q <= db_q;
                        cnt_q     <= cnt_d;
                    end
                end

                // Rising edge of the debounced level only; release is silent
                // and a held button produces exactly one pulse.
                assign press[gi] = db_q & ~db_prev_q;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sticky request latches
    // -------------------------------------------------------------------------
    logic              floor_ok;
    logic [FLOORS-1:0] serve_hit;
    logic [FLOORS-1:0] queue_up_q;
    logic [FLOORS-1:0] queue_up_d;
    logic [FLOORS-1:0] queue_down_q;
    logic [FLOORS-1:0] queue_down_d;
    logic [FLOORS-1:0] queue_inside_q;
    logic [FLOORS-1:0] queue_inside_d;

    // An out-of-range floor index disables serving and the summaries.
    assign floor_ok = (int'(cur_floor) < FLOORS);

    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_floor
            assign serve_hit[gi] = serve_valid & floor_ok & (cur_floor == FW'(gi));

            // Clear has priority over a same-cycle set: the press is treated
            // as already served.
            assign queue_up_d[gi] = (queue_up_q[gi] | press[gi])
                                  & ~(serve_hit[gi] & serve_dir)
                                  & UP_MASK[gi];

            assign queue_down_d[gi] = (queue_down_q[gi] | press[FLOORS + gi])
                                    & ~(serve_hit[gi] & ~serve_dir)
                                    & DN_MASK[gi];

            assign queue_inside_d[gi] = (queue_inside_q[gi] | press[2*FLOORS + gi])
                                      & ~serve_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue_up_q     <= '0;
            queue_down_q   <= '0;
            queue_inside_q <= '0;
        end else begin
            queue_up_q     <= queue_up_d;
            queue_down_q   <= queue_down_d;
            queue_inside_q <= queue_inside_d;
        end
    end

    assign queue_up     = queue_up_q;
    assign queue_down   = queue_down_q;
    assign queue_inside = queue_inside_q;

    // -------------------------------------------------------------------------
    // Position summaries, purely combinational from the registered queues
    // -------------------------------------------------------------------------
    logic [FLOORS-1:0] pending;

    assign pending = queue_up_q | queue_down_q | queue_inside_q;

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        req_here  = 1'b0;
        if (floor_ok) begin
            for (int j = 0; j < FLOORS; j++) begin
                if (j > int'(cur_floor)) begin
                    req_above = req_above | pending[j];
                end
                if (j < int'(cur_floor)) begin
                    req_below = req_below | pending[j];
                end
                if (j == int'(cur_floor)) begin
                    req_here = req_here | pending[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_elevator_request_queue.sv
`timescale 1ns/1ps
module tb_elevator_request_queue;

    logic clk = 1'b0;
    always #2.5 clk = ~clk;

    logic       rst = 1'b1;
    // FLOORS=4 instance
    logic [3:0] outside_up = '0, outside_down = '0, inside_floor = '0;
    logic [1:0] cur_floor = '0;
    logic       serve_valid = 1'b0, serve_dir = 1'b0;
    logic [3:0] queue_up, queue_down, queue_inside;
    logic       req_above, req_below, req_here;
    // FLOORS=5 instance
    logic [4:0] up5 = '0, dn5 = '0, in5 = '0;
    logic [2:0] cf5 = '0;
    logic       sv5 = 1'b0, sd5 = 1'b0;
    logic [4:0] qu5, qd5, qi5;
    logic       ab5, bl5, hr5;

    elevator_request_queue #(.FLOORS(4), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .outside_up(outside_up), .outside_down(outside_down), .inside_floor(inside_floor),
        .cur_floor(cur_floor), .serve_valid(serve_valid), .serve_dir(serve_dir),
        .queue_up(queue_up), .queue_down(queue_down), .queue_inside(queue_inside),
        .req_above(req_above), .req_below(req_below), .req_here(req_here)
    );

    elevator_request_queue #(.FLOORS(5), .DEB_CYCLES(4)) dut5 (
        .clk(clk), .rst(rst),
        .outside_up(up5), .outside_down(dn5), .inside_floor(in5),
        .cur_floor(cf5), .serve_valid(sv5), .serve_dir(sd5),
        .queue_up(qu5), .queue_down(qd5), .queue_inside(qi5),
        .req_above(ab5), .req_below(bl5), .req_here(hr5)
    );

    // Scoreboard of expected packed outputs {above,below,here,inside,down,up}.
    logic [17:0] sb_q[$];
    logic [17:0] exp_v, got_v;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [17:0] pk4(input logic a, input logic b, input logic h,
                                        input logic [3:0] ins, input logic [3:0] dn,
                                        input logic [3:0] up);
        return {a, b, h, 1'b0, ins, 1'b0, dn, 1'b0, up};
    endfunction

    function automatic logic [17:0] pk5(input logic a, input logic b, input logic h,
                                        input logic [4:0] ins, input logic [4:0] dn,
                                        input logic [4:0] up);
        return {a, b, h, ins, dn, up};
    endfunction

    function automatic logic [17:0] obs4();
        return pk4(req_above, req_below, req_here, queue_inside, queue_down, queue_up);
    endfunction

    function automatic logic [17:0] obs5();
        return pk5(ab5, bl5, hr5, qi5, qd5, qu5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        outside_up = '0; outside_down = '0; inside_floor = '0;
        cur_floor = '0; serve_valid = 1'b0; serve_dir = 1'b0;
        up5 = '0; dn5 = '0; in5 = '0; cf5 = '0; sv5 = 1'b0; sd5 = 1'b0;
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        sb_q.push_back(pk5(1'b0, 1'b0, 1'b0, 5'h0, 5'h0, 5'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL reset4: got %h required %h", got_v, exp_v); end
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL reset5: got %h required %h", got_v, exp_v); end
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_press();
        do_reset();
        inside_floor = 4'b0100;                     // E0 is the next edge
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0));
        sb_q.push_back(pk4(1'b1, 1'b0, 1'b0, 4'b0100, 4'h0, 4'h0));
        repeat (6) tick();                          // after E0+5
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL clean_e5: got %h required %h", got_v, exp_v); end
        tick();                                     // after E0+6
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL clean_e6: got %h required %h", got_v, exp_v); end
        cur_floor = 2'd2; #1;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b1, 4'b0100, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL clean_here: got %h required %h", got_v, exp_v); end
        cur_floor = 2'd3; #1;
        sb_q.push_back(pk4(1'b0, 1'b1, 1'b0, 4'b0100, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL clean_below: got %h required %h", got_v, exp_v); end
        repeat (10) tick();
        sb_q.push_back(pk4(1'b0, 1'b1, 1'b0, 4'b0100, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL clean_hold: got %h required %h", got_v, exp_v); end
        $display("[TB] test_clean_press done");
    endtask

    task automatic test_glitch();
        do_reset();
        outside_up = 4'b0010;
        repeat (3) tick();
        outside_up = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
            repeat (3) tick();
            exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL glitch_%0d: got %h required %h", k, got_v, exp_v); end
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        do_reset();
        pat = 7'b1111011;                           // sampled LSB first: 1,1,0,1,1,1,1
        for (int k = 0; k < 7; k++) begin
            outside_up[1] = pat[k];
            tick();                                 // edge E_k
        end
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0000));
        sb_q.push_back(pk4(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'b0010));
        tick(); tick();                             // after E8 = last rise + 5
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL bounce_e5: got %h required %h", got_v, exp_v); end
        tick();                                     // after E9 = last rise + 6
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL bounce_e6: got %h required %h", got_v, exp_v); end
        $display("[TB] test_bounce done");
    endtask

    task automatic test_dir_clear();
        do_reset();
        outside_up = 4'b0100; outside_down = 4'b0100;
        repeat (7) tick();
        outside_up = 4'b0000; outside_down = 4'b0000;
        cur_floor = 2'd2; #1;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b1, 4'h0, 4'b0100, 4'b0100));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL dir_both: got %h required %h", got_v, exp_v); end
        serve_valid = 1'b1; serve_dir = 1'b1;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b1, 4'h0, 4'b0100, 4'b0000));
        tick();
        serve_valid = 1'b0;
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL dir_up: got %h required %h", got_v, exp_v); end
        serve_valid = 1'b1; serve_dir = 1'b0;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000));
        tick();
        serve_valid = 1'b0;
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL dir_down: got %h required %h", got_v, exp_v); end
        $display("[TB] test_dir_clear done");
    endtask

    task automatic test_set_clear();
        do_reset();
        cur_floor = 2'd1;
        inside_floor = 4'b0010;
        repeat (6) tick();                          // after E0+5, press event next edge
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL setclr_pre: got %h required %h", got_v, exp_v); end
        serve_valid = 1'b1; serve_dir = 1'b0;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        tick();                                     // E0+6: set and clear together
        serve_valid = 1'b0;
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL setclr_edge: got %h required %h", got_v, exp_v); end
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        repeat (12) tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL setclr_hold: got %h required %h", got_v, exp_v); end
        $display("[TB] test_set_clear done");
    endtask

    task automatic test_tieoff();
        do_reset();
        outside_up = 4'b1000; outside_down = 4'b0001;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        repeat (12) tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL tieoff: got %h required %h", got_v, exp_v); end
        $display("[TB] test_tieoff done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        cur_floor = 2'd1;
        outside_up = 4'b0001; outside_down = 4'b1000; inside_floor = 4'b0110;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        sb_q.push_back(pk4(1'b1, 1'b1, 1'b1, 4'b0110, 4'b1000, 4'b0001));
        repeat (6) tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL b2b_e5: got %h required %h", got_v, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL b2b_e6: got %h required %h", got_v, exp_v); end
        serve_valid = 1'b1; serve_dir = 1'b1;
        sb_q.push_back(pk4(1'b1, 1'b1, 1'b0, 4'b0100, 4'b1000, 4'b0001));
        tick();
        serve_valid = 1'b0;
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL b2b_serve: got %h required %h", got_v, exp_v); end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_illegal_floor();
        do_reset();
        in5 = 5'b10001; up5 = 5'b00100;
        repeat (7) tick();
        in5 = '0; up5 = '0;
        cf5 = 3'd2; #1;
        sb_q.push_back(pk5(1'b1, 1'b1, 1'b1, 5'b10001, 5'h0, 5'b00100));
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL ill_mid: got %h required %h", got_v, exp_v); end
        cf5 = 3'd4; #1;
        sb_q.push_back(pk5(1'b0, 1'b1, 1'b1, 5'b10001, 5'h0, 5'b00100));
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL ill_top: got %h required %h", got_v, exp_v); end
        cf5 = 3'd7; #1;
        sb_q.push_back(pk5(1'b0, 1'b0, 1'b0, 5'b10001, 5'h0, 5'b00100));
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL ill_summ: got %h required %h", got_v, exp_v); end
        sv5 = 1'b1; sd5 = 1'b1;
        tick();
        sd5 = 1'b0;
        tick();
        sv5 = 1'b0;
        sb_q.push_back(pk5(1'b0, 1'b0, 1'b0, 5'b10001, 5'h0, 5'b00100));
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL ill_serve: got %h required %h", got_v, exp_v); end
        cf5 = 3'd4; sv5 = 1'b1; sd5 = 1'b1;
        sb_q.push_back(pk5(1'b0, 1'b1, 1'b0, 5'b00001, 5'h0, 5'b00100));
        tick();
        sv5 = 1'b0;
        exp_v = sb_q.pop_front(); got_v = obs5(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL ill_top_serve: got %h required %h", got_v, exp_v); end
        $display("[TB] test_illegal_floor done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        inside_floor = 4'b1001;
        repeat (7) tick();
        inside_floor = 4'b0000;
        sb_q.push_back(pk4(1'b1, 1'b0, 1'b1, 4'b1001, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL rstmid_pre: got %h required %h", got_v, exp_v); end
        outside_down = 4'b1000;
        repeat (3) tick();                          // mid-debounce
        rst = 1'b1;
        #1;
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0));
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL rstmid_async: got %h required %h", got_v, exp_v); end
        tick();
        rst = 1'b0;                                 // next edge is the first sampling edge
        sb_q.push_back(pk4(1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'h0));
        sb_q.push_back(pk4(1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 4'h0));
        repeat (6) tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL rstmid_e5: got %h required %h", got_v, exp_v); end
        tick();
        exp_v = sb_q.pop_front(); got_v = obs4(); n_tests++;
        if (got_v !== exp_v) begin n_fail++; $display("FAIL rstmid_e6: got %h required %h", got_v, exp_v); end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_dir_clear();
        test_set_clear();
        test_tieoff();
        test_back_to_back();
        test_illegal_floor();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
